// File: rtl/spi_slave_device_if.sv
// SPI slave bus plus TX/RX word handshakes for spi_slave_device.
// Ports: SCK/CSbar/MOSI/MISO/MISO_OE pins, TX holding handshake, RX word and status pulses.
interface spi_slave_device_if #(
  parameter int unsigned DBITS = 16
);
  logic             SCK;
  logic             CSbar;
  logic             MOSI;
  logic             MISO;
  logic             MISO_OE;
  logic [DBITS-1:0] TX_DATA;
  logic             TX_VALID;
  logic             TX_READY;
  logic [DBITS-1:0] RX_DATA;
  logic             RX_VALID;
  logic             UNDERRUN;
  logic             ABORT;

  modport slave (
    input  SCK, CSbar, MOSI, TX_DATA, TX_VALID,
    output MISO, MISO_OE, TX_READY,
    output RX_DATA, RX_VALID, UNDERRUN, ABORT
  );

  modport master (
    output SCK, CSbar, MOSI, TX_DATA, TX_VALID,
    input  MISO, MISO_OE, TX_READY,
    input  RX_DATA, RX_VALID, UNDERRUN, ABORT
  );
endinterface

// File: rtl/spi_slave_device.sv
// Oversampled SPI mode-0 slave: SYS_CLK domain only, TX holding reg, RX word out.
// Ports: SYS_CLK, RESETbar (async low), bus (spi_slave_device_if.slave).
module spi_slave_device #(
  parameter int unsigned      DBITS       = 16,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [DBITS-1:0] IDLE_WORD   = '0
) (
  input  logic               SYS_CLK,
  input  logic               RESETbar,
  spi_slave_device_if.slave  bus
);

  localparam int unsigned    CW   = $clog2(DBITS + 1);
  localparam logic [CW-1:0]  FULL = CW'(DBITS);
  localparam logic           IMSB = IDLE_WORD[DBITS-1];

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  // One extra flop past the synchroniser gives the edge reference.
  logic [SYNC_STAGES:0]   sck_q;
  logic [SYNC_STAGES:0]   cs_q;
  logic [SYNC_STAGES-1:0] mosi_q;

  always_ff @(posedge SYS_CLK or negedge RESETbar) begin
    if (!RESETbar) begin
      sck_q  <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[SYNC_STAGES-1:0], bus.SCK};
      cs_q   <= {cs_q[SYNC_STAGES-1:0], bus.CSbar};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.MOSI};
    end
  end

  logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;

  assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_q[SYNC_STAGES];
  assign sck_fall = ~sck_q[SYNC_STAGES-1] & sck_q[SYNC_STAGES];
  assign cs_fall  = ~cs_q[SYNC_STAGES-1] & cs_q[SYNC_STAGES];
  assign cs_rise  = cs_q[SYNC_STAGES-1] & ~cs_q[SYNC_STAGES];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];

  state_t           state_q;
  logic [CW-1:0]    bit_cnt_q;
  logic [DBITS-1:0] shift_rx_q;
  logic [DBITS-1:0] shift_tx_q;
  logic [DBITS-1:0] hold_q;
  logic             hold_full_q;
  logic [DBITS-1:0] rx_data_q;
  logic             rx_valid_q;
  logic             underrun_q;
  logic             abort_q;
  logic             miso_q;
  logic             oe_q;

  logic word_done;
  logic tx_load;

  assign word_done = (state_q == ACTIVE) && (bit_cnt_q == FULL);

  // Load at frame start and at each word boundary still inside the frame.
  always_comb begin
    tx_load = 1'b0;
    unique case (1'b1)
      state_q == IDLE:   tx_load = cs_fall;
      state_q == ACTIVE: tx_load = word_done & ~cs_rise;
      default:           tx_load = 1'b0;
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge RESETbar) begin
    if (!RESETbar) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_rx_q  <= '0;
      shift_tx_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;

      if (tx_load) begin
        if (hold_full_q) begin
          shift_tx_q  <= hold_q;
          miso_q      <= hold_q[DBITS-1];
          hold_full_q <= 1'b0;
        end else begin
          shift_tx_q <= IDLE_WORD;
          miso_q     <= IMSB;
          underrun_q <= 1'b1;
        end
      end

      // Only accepted while empty, so never races the load above.
      if (bus.TX_VALID && !hold_full_q) begin
        hold_q      <= bus.TX_DATA;
        hold_full_q <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q   <= ACTIVE;
            bit_cnt_q <= '0;
            oe_q      <= 1'b1;
          end
        end
        ACTIVE: begin
          if (word_done) begin
            rx_data_q  <= shift_rx_q;
            rx_valid_q <= 1'b1;
            bit_cnt_q  <= '0;
          end
          if (cs_rise) begin
            state_q <= IDLE;
            oe_q    <= 1'b0;
            miso_q  <= 1'b0;
            if (bit_cnt_q != '0 && !word_done)
              abort_q <= 1'b1;
          end else if (word_done) begin
            // TX reload handled above.
          end else if (sck_rise) begin
            shift_rx_q <= {shift_rx_q[DBITS-2:0], mosi_s};
            bit_cnt_q  <= bit_cnt_q + 1'b1;
          end else if (sck_fall && bit_cnt_q != '0) begin
            shift_tx_q <= shift_tx_q << 1;
            miso_q     <= shift_tx_q[DBITS-2];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.MISO     = miso_q;
  assign bus.MISO_OE  = oe_q;
  assign bus.TX_READY = ~hold_full_q;
  assign bus.RX_DATA  = rx_data_q;
  assign bus.RX_VALID = rx_valid_q;
  assign bus.UNDERRUN = underrun_q;
  assign bus.ABORT    = abort_q;

endmodule

// File: tb/tb_spi_slave_device.sv
// Directed bench for spi_slave_device: master frames, TX feeder, pulse monitor.
// Ports: none (top-level bench).
`timescale 1ns/1ps
module tb_spi_slave_device;

  logic clk;
  logic rst_n;

  spi_slave_device_if #(.DBITS(16)) bus ();

  spi_slave_device #(
    .DBITS(16),
    .SYNC_STAGES(2),
    .IDLE_WORD(16'h0000)
  ) dut (
    .SYS_CLK (clk),
    .RESETbar(rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #12.5 clk = ~clk;

  int n_vec;
  int n_err;
  int rx_cnt;
  int und_cnt;
  int abt_cnt;
  int hs_cnt;
  logic [15:0] rx_q[$];
  logic [15:0] sent_q[$];

  always @(negedge clk) begin
    if (bus.RX_VALID) begin
      rx_cnt++;
      rx_q.push_back(bus.RX_DATA);
    end
    if (bus.UNDERRUN) und_cnt++;
    if (bus.ABORT) abt_cnt++;
    if (bus.TX_VALID && bus.TX_READY) hs_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tx_push(input logic [15:0] w);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    bus.TX_DATA  = w;
    bus.TX_VALID = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (bus.TX_READY) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.TX_VALID = 1'b0;
    if (ok) sent_q.push_back(w);
    else chk("tx_push_timeout", 64'(ok), 64'd1);
  endtask

  task automatic spi_frame(input int nbits,
                           input logic [63:0] mo,
                           input int half,
                           input bit end_cs,
                           output logic [63:0] mi,
                           output int und_last);
    mi = '0;
    und_last = und_cnt;
    @(negedge clk);
    bus.CSbar = 1'b0;
    #200;
    for (int i = 0; i < nbits; i++) begin
      bus.MOSI = mo[nbits-1-i];
      #(half);
      mi = {mi[62:0], bus.MISO};
      if (i == nbits - 1) und_last = und_cnt;
      bus.SCK = 1'b1;
      #(half);
      bus.SCK = 1'b0;
    end
    #(half);
    if (end_cs) bus.CSbar = 1'b1;
    #400;
  endtask

  logic [63:0] mi;
  int ul;
  int u0;
  int r0;
  int a0;
  int h0;
  logic [15:0] keep;

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0;
    rx_cnt = 0; und_cnt = 0; abt_cnt = 0; hs_cnt = 0;
    rst_n = 1'b0;
    bus.SCK = 1'b0;
    bus.CSbar = 1'b1;
    bus.MOSI = 1'b0;
    bus.TX_DATA = '0;
    bus.TX_VALID = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_miso", 64'(bus.MISO), 64'd0);
    chk("rst_oe", 64'(bus.MISO_OE), 64'd0);
    chk("rst_ready", 64'(bus.TX_READY), 64'd1);
    chk("rst_rxdata", 64'(bus.RX_DATA), 64'd0);
    chk("rst_rxvalid", 64'(bus.RX_VALID), 64'd0);
    chk("rst_underrun", 64'(bus.UNDERRUN), 64'd0);
    chk("rst_abort", 64'(bus.ABORT), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: preloaded word, single frame
    tx_push(16'hA5C3);
    u0 = und_cnt; r0 = rx_cnt;
    spi_frame(16, 64'h1234, 100, 1'b1, mi, ul);
    chk("t1_miso", mi, 64'hA5C3);
    chk("t1_rxdata", 64'(bus.RX_DATA), 64'h1234);
    chk("t1_rxcnt", 64'(rx_cnt - r0), 64'd1);
    chk("t1_under", 64'(ul - u0), 64'd0);

    // 1b: receive at 10 MHz (2 SYS_CLK half period)
    r0 = rx_cnt;
    spi_frame(16, 64'h8001, 50, 1'b1, mi, ul);
    chk("t1b_rxdata", 64'(bus.RX_DATA), 64'h8001);
    chk("t1b_rxcnt", 64'(rx_cnt - r0), 64'd1);

    // 2: underrun
    u0 = und_cnt;
    spi_frame(16, 64'hFFFF, 100, 1'b1, mi, ul);
    chk("t2_miso", mi, 64'h0000);
    chk("t2_under_csfall", 64'(ul - u0), 64'd1);
    chk("t2_under_total", 64'(und_cnt - u0), 64'd2);
    chk("t2_rxdata", 64'(bus.RX_DATA), 64'hFFFF);

    // 3: back-to-back words in one frame
    tx_push(16'h1111);
    rx_q.delete();
    u0 = und_cnt;
    fork
      spi_frame(32, 64'hABCD5678, 100, 1'b1, mi, ul);
      tx_push(16'h2222);
    join
    chk("t3_miso", mi, 64'h11112222);
    chk("t3_rxcnt", 64'(rx_q.size()), 64'd2);
    if (rx_q.size() == 2) begin
      chk("t3_rx0", 64'(rx_q[0]), 64'hABCD);
      chk("t3_rx1", 64'(rx_q[1]), 64'h5678);
    end
    chk("t3_under", 64'(ul - u0), 64'd0);

    // 4: abort after 7 bits
    keep = bus.RX_DATA;
    r0 = rx_cnt; a0 = abt_cnt;
    spi_frame(7, 64'h55, 100, 1'b1, mi, ul);
    chk("t4_abort", 64'(abt_cnt - a0), 64'd1);
    chk("t4_rxcnt", 64'(rx_cnt - r0), 64'd0);
    chk("t4_rxkeep", 64'(bus.RX_DATA), 64'(keep));
    tx_push(16'hBEEF);
    spi_frame(16, 64'h0F0F, 100, 1'b1, mi, ul);
    chk("t4_next_miso", mi, 64'hBEEF);
    chk("t4_next_rx", 64'(bus.RX_DATA), 64'h0F0F);

    // 5: reset at bit 9
    spi_frame(9, 64'h1FF, 100, 1'b0, mi, ul);
    tx_push(16'h7777);
    chk("t5_pre_oe", 64'(bus.MISO_OE), 64'd1);
    chk("t5_pre_ready", 64'(bus.TX_READY), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("t5_oe", 64'(bus.MISO_OE), 64'd0);
    chk("t5_miso", 64'(bus.MISO), 64'd0);
    chk("t5_ready", 64'(bus.TX_READY), 64'd1);
    chk("t5_rxdata", 64'(bus.RX_DATA), 64'd0);
    chk("t5_rxvalid", 64'(bus.RX_VALID), 64'd0);
    bus.CSbar = 1'b1;
    bus.SCK = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tx_push(16'h5A5A);
    spi_frame(16, 64'hC3A5, 100, 1'b1, mi, ul);
    chk("t5_after_miso", mi, 64'h5A5A);
    chk("t5_after_rx", 64'(bus.RX_DATA), 64'hC3A5);

    // 6: feeder stalls on full holding across boundaries
    sent_q.delete();
    rx_q.delete();
    h0 = hs_cnt;
    u0 = und_cnt;
    tx_push(16'h0A01);
    fork
      spi_frame(48, 64'h111122223333, 100, 1'b1, mi, ul);
      begin
        tx_push(16'h0B02);
        tx_push(16'h0C03);
      end
    join
    chk("t6_hs", 64'(hs_cnt - h0), 64'd3);
    chk("t6_under", 64'(ul - u0), 64'd0);
    chk("t6_sent", 64'(sent_q.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < sent_q.size())
        chk($sformatf("t6_word%0d", i),
            64'(mi[47-16*i -: 16]), 64'(sent_q[i]));
    end
    chk("t6_rxcnt", 64'(rx_q.size()), 64'd3);
    if (rx_q.size() == 3) begin
      chk("t6_rx0", 64'(rx_q[0]), 64'h1111);
      chk("t6_rx1", 64'(rx_q[1]), 64'h2222);
      chk("t6_rx2", 64'(rx_q[2]), 64'h3333);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
